cache_controller: RTL and testbench

Control FSM that sequences the direct-mapped cache datapath for one read access per `start` request. On a hit it returns immediately. On a miss it fetches a full block from main memory word by word, writes the block and then the tag/valid bit, and signals completion. It sits between the processor-side handshake (`start`/`ready`) and the cache datapath plus main-memory read port. It also keeps hit and access counters for performance measurement.

---
 rtl/cache_controller.sv | 123 ++++++++++++
 tb/tb_cache_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped cache: one read access per start request,
// block refill from main memory on a miss, plus hit/access counters.
module cache_controller #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CNT_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hit,
  input  logic                     mem_ready,
  output logic                     addr_ld,
  output logic                     mem_read,
  output logic [$clog2(WORDS)-1:0] word_sel,
  output logic                     data_we,
  output logic                     tag_we,
  output logic                     ready,
  output logic                     h_m,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         acc_count
);

  localparam int unsigned     WL   = $clog2(WORDS);
  localparam logic [WL-1:0]   LAST = WL'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    UPDATE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WL-1:0]      word_sel_q, word_sel_d;
  logic               h_m_q, h_m_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

  // Next-state, datapath strobes and counter updates.
  always_comb begin
    state_d    = state_q;
    word_sel_d = word_sel_q;
    h_m_d      = h_m_q;
    hit_cnt_d  = hit_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    addr_ld    = 1'b0;
    mem_read   = 1'b0;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    ready      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Suppressed under reset so a start coinciding with rst latches nothing.
          addr_ld = ~rst;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          h_m_d     = 1'b1;
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          state_d   = DONE;
        end else begin
          h_m_d      = 1'b0;
          word_sel_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        data_we  = mem_ready;
        if (mem_ready) begin
          // WORDS is a power of two, so the increment past LAST wraps to 0.
          word_sel_d = word_sel_q + WL'(1);
          if (word_sel_q == LAST) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        tag_we    = 1'b1;
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
        state_d   = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_sel_q <= '0;
      h_m_q      <= 1'b0;
      hit_cnt_q  <= '0;
      acc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_sel_q <= word_sel_d;
      h_m_q      <= h_m_d;
      hit_cnt_q  <= hit_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign word_sel  = word_sel_q;
  assign h_m       = h_m_q;
  assign hit_count = hit_cnt_q;
  assign acc_count = acc_cnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: the driver predicts every strobe and
// completion cycle from the access rules; a negedge monitor pops and compares.
module tb_cache_controller;

  localparam int WORDS = 4;
  localparam int CNT_W = 3;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic             hit;
  logic             mem_ready;
  logic             addr_ld;
  logic             mem_read;
  logic [1:0]       word_sel;
  logic             data_we;
  logic             tag_we;
  logic             ready;
  logic             h_m;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] acc_count;

  cache_controller #(
    .WORDS(WORDS),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .mem_ready (mem_ready),
    .addr_ld   (addr_ld),
    .mem_read  (mem_read),
    .word_sel  (word_sel),
    .data_we   (data_we),
    .tag_we    (tag_we),
    .ready     (ready),
    .h_m       (h_m),
    .hit_count (hit_count),
    .acc_count (acc_count)
  );

  typedef struct {
    int word;
    int cyc;
  } we_t;

  typedef struct {
    int rise;
    int fall;
    int hm;
    int hits;
    int accs;
  } rdy_t;

  int   q_addr[$];
  we_t  q_we[$];
  int   q_tag[$];
  rdy_t q_rdy[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   m_hit  = 0;
  int   m_acc  = 0;
  bit   mon_en = 1'b0;
  bit   rdy_prev = 1'b0;
  bit   cur_valid = 1'b0;
  rdy_t cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe/completion the DUT shows must match the head of its queue.
  always @(negedge clk) begin
    we_t  e;
    if (mon_en) begin
      if (addr_ld) begin
        if (q_addr.size() == 0) chk("addr_ld_extra", 1, 0);
        else chk("addr_ld_cycle", cyc, q_addr.pop_front());
      end
      if (data_we) begin
        if (q_we.size() == 0) chk("data_we_extra", 1, 0);
        else begin
          e = q_we.pop_front();
          chk("data_we_cycle", cyc, e.cyc);
          chk("word_sel", int'(word_sel), e.word);
          chk("mem_read_during_write", int'(mem_read), 1);
        end
      end
      if (tag_we) begin
        if (q_tag.size() == 0) chk("tag_we_extra", 1, 0);
        else chk("tag_we_cycle", cyc, q_tag.pop_front());
      end
      if (ready && !rdy_prev) begin
        if (q_rdy.size() == 0) chk("ready_extra", 1, 0);
        else begin
          cur = q_rdy.pop_front();
          cur_valid = 1'b1;
          chk("ready_rise_cycle", cyc, cur.rise);
          chk("h_m", int'(h_m), cur.hm);
          chk("hit_count", int'(hit_count), cur.hits);
          chk("acc_count", int'(acc_count), cur.accs);
        end
      end
      if (!ready && rdy_prev && cur_valid) begin
        chk("ready_fall_cycle", cyc, cur.fall + 1);
        cur_valid = 1'b0;
      end
    end
    rdy_prev = ready;
  end

  // One access: w* are wait cycles before each memory word; hold_in=0 picks a random start hold.
  task automatic do_access(input bit h, input int w0, input int w1, input int w2, input int w3,
                           input int hold_in);
    int wt[WORDS];
    bit fr[$];
    int c, f, r, d, hold, word;
    wt = '{w0, w1, w2, w3};
    c = cyc;
    for (int i = 0; i < WORDS; i++) begin
      repeat (wt[i]) fr.push_back(1'b0);
      fr.push_back(1'b1);
    end
    f = fr.size();
    q_addr.push_back(c);
    if (h) begin
      r = c + 2;
    end else begin
      word = 0;
      for (int i = 0; i < f; i++) begin
        if (fr[i]) begin
          q_we.push_back('{word, c + 2 + i});
          word++;
        end
      end
      q_tag.push_back(c + 2 + f);
      r = c + 3 + f;
    end
    hold = (hold_in != 0) ? hold_in : 1 + int'($urandom_range(r - c + 2));
    d = (r > c + hold) ? r : c + hold;
    m_acc = (m_acc + 1) % CMOD;
    if (h) m_hit = (m_hit + 1) % CMOD;
    q_rdy.push_back('{r, d, int'(h), m_hit, m_acc});
    for (int k = 0; k <= d - c; k++) begin
      start     = (k < hold);
      hit       = (k == 1) ? h : 1'($urandom);
      mem_ready = (!h && k >= 2 && k - 2 < f) ? fr[k - 2] : 1'($urandom);
      step();
    end
    start = 1'b0;
  endtask

  // Miss aborted by reset once words 0..2 have been written.
  task automatic reset_mid();
    int c;
    c = cyc;
    q_addr.push_back(c);
    for (int i = 0; i < 3; i++) q_we.push_back('{i, c + 2 + i});
    for (int k = 0; k < 5; k++) begin
      start     = (k == 0);
      hit       = 1'b0;
      mem_ready = (k >= 2);
      step();
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hit = 0;
    m_acc = 0;
    @(negedge clk);
    chk("rstmid_ready", int'(ready), 0);
    chk("rstmid_mem_read", int'(mem_read), 0);
    chk("rstmid_word_sel", int'(word_sel), 0);
    chk("rstmid_h_m", int'(h_m), 0);
    chk("rstmid_hit_count", int'(hit_count), 0);
    chk("rstmid_acc_count", int'(acc_count), 0);
    step();
    repeat (4) step();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    hit = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_addr_ld", int'(addr_ld), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_data_we", int'(data_we), 0);
    chk("rst_tag_we", int'(tag_we), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_h_m", int'(h_m), 0);
    chk("rst_word_sel", int'(word_sel), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_acc_count", int'(acc_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    hit = 1'b0;
    mem_ready = 1'b0;
    mon_en = 1'b1;
    repeat (3) step();

    do_access(1'b1, 0, 0, 0, 0, 1);
    do_access(1'b0, 0, 0, 0, 0, 1);
    do_access(1'b0, 2, 2, 2, 2, 1);
    do_access(1'b1, 0, 0, 0, 0, 10);
    repeat (2) step();
    do_access(1'b1, 0, 0, 0, 0, 1);
    reset_mid();

    for (int i = 0; i < 8; i++) do_access(1'b1, 0, 0, 0, 0, 0);
    do_access(1'b0, 1, 0, 0, 2, 0);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), int'($urandom_range(2)), int'($urandom_range(2)),
                int'($urandom_range(2)), int'($urandom_range(2)), 0);
      repeat ($urandom_range(2)) begin
        hit = 1'($urandom);
        mem_ready = 1'($urandom);
        step();
      end
    end

    repeat (6) step();
    chk("left_addr_ld", q_addr.size(), 0);
    chk("left_data_we", q_we.size(), 0);
    chk("left_tag_we", q_tag.size(), 0);
    chk("left_ready", q_rdy.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
